jts16_trackball_emu: RTL and testbench



---
 rtl/jts16_trackball_emu_pkg.sv | 34 +++
 rtl/jts16_trackball_emu_axis.sv | 48 ++++
 rtl/jts16_trackball_emu.sv | 103 ++++++++++
 tb/tb_jts16_trackball_emu.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/jts16_trackball_emu_pkg.sv
// Shared constants and helpers for the System 16B trackball emulation.
// Optional feature macro: JTS16_TRACKBALL_DIGITAL_EN (digital joystick fallback).
package jts16_trackball_emu_pkg;

  localparam int TB_DEADZONE = 8;
  localparam int TB_SHIFT    = 3;
  localparam int TB_DIG_STEP = 8;
  localparam int TB_LINES    = 16;
  localparam int TB_W        = 12;

  localparam int TB_LCNT_W = $clog2(TB_LINES);

  localparam logic [TB_LCNT_W-1:0] TB_LINE_LAST = TB_LCNT_W'(TB_LINES - 1);
  localparam logic signed [7:0]    TB_DZ_POS    = 8'(TB_DEADZONE);
  localparam logic [TB_W-1:0]      TB_DIG_PLUS  = TB_W'(TB_DIG_STEP);
  localparam logic [TB_W-1:0]      TB_DIG_MINUS = TB_W'(-TB_DIG_STEP);

  // True while the stick sits inside the dead zone (|axis| < TB_DEADZONE)
  function automatic logic in_deadzone(input logic [7:0] axis);
    logic signed [7:0] s;
    s = axis;
    return (s < TB_DZ_POS) && (s > -TB_DZ_POS);
  endfunction

  // Scaled stick deflection, sign-extended to the counter width
  function automatic logic [TB_W-1:0] analog_delta(input logic [7:0] axis);
    logic signed [7:0] s;
    logic signed [7:0] sh;
    s  = axis;
    sh = s >>> TB_SHIFT;
    return {{(TB_W-8){sh[7]}}, sh};
  endfunction

endpackage

// File: rtl/jts16_trackball_emu_axis.sv
// One trackball axis: position counter, dead-zone / digital source mux and adder.
// Optional feature macro: JTS16_TRACKBALL_DIGITAL_EN (digital joystick fallback).
module jts16_trackball_axis
  import jts16_trackball_emu_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            strobe,
  input  logic [7:0]      axis,
  input  logic            plus,
  input  logic            minus,
  output logic [TB_W-1:0] count
);

  logic [TB_W-1:0] delta;

`ifndef JTS16_TRACKBALL_DIGITAL_EN
  logic unused_dig;
  assign unused_dig = plus ^ minus;
`endif

  // Pick the step: analogue outside the dead zone, otherwise the digital buttons
  always_comb begin
    delta = '0;
    if (!in_deadzone(axis)) begin
      delta = analog_delta(axis);
    end else begin
`ifdef JTS16_TRACKBALL_DIGITAL_EN
      case ({plus, minus})
        2'b10:   delta = TB_DIG_PLUS;
        2'b01:   delta = TB_DIG_MINUS;
        default: delta = '0;
      endcase
`else
      delta = '0;
`endif
    end
  end

  // Integrate the step on each update strobe; wraps modulo 2^TB_W
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      count <= '0;
    else if (strobe)
      count <= count + delta;
  end

endmodule

// File: rtl/jts16_trackball_emu.sv
// Eight trackball/dial position counters for four players, driven by analogue
// sticks and digital joysticks, updated once every TB_LINES video lines.
// Optional feature macro: JTS16_TRACKBALL_DIGITAL_EN (digital joystick fallback).
module jts16_trackball_emu
  import jts16_trackball_emu_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            LHBL,
  input  logic            right_en,
  input  logic [7:0]      joystick1,
  input  logic [7:0]      joystick2,
  input  logic [7:0]      joystick3,
  input  logic [7:0]      joystick4,
  input  logic [15:0]     joyana1,
  input  logic [15:0]     joyana2,
  input  logic [15:0]     joyana3,
  input  logic [15:0]     joyana4,
  input  logic [15:0]     joyana1b,
  input  logic [15:0]     joyana2b,
  output logic [TB_W-1:0] trackball0,
  output logic [TB_W-1:0] trackball1,
  output logic [TB_W-1:0] trackball2,
  output logic [TB_W-1:0] trackball3,
  output logic [TB_W-1:0] trackball4,
  output logic [TB_W-1:0] trackball5,
  output logic [TB_W-1:0] trackball6,
  output logic [TB_W-1:0] trackball7
);

  logic                 LHBL_l;
  logic [TB_LCNT_W-1:0] line_cnt;
  logic                 tick;
  logic                 strobe;
  logic [15:0]          ana [4];
  logic [7:0]           joy [4];
  logic [TB_W-1:0]      cnt [8];
  logic                 unused_joy;

  assign unused_joy = ^{joystick1[7:4], joystick2[7:4], joystick3[7:4], joystick4[7:4]};

  assign tick   = LHBL_l & ~LHBL;
  assign strobe = tick && (line_cnt == TB_LINE_LAST);

  // Remember last LHBL so a falling edge can be spotted
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      LHBL_l <= 1'b1;
    else
      LHBL_l <= LHBL;
  end

  // Count lines; the natural wrap of the counter gives the 16-line frame
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      line_cnt <= '0;
    else if (tick)
      line_cnt <= line_cnt + 1'b1;
  end

  // Choose each player's analogue source; only players 1/2 have right sticks
  always_comb begin
    ana[0] = right_en ? joyana1b : joyana1;
    ana[1] = right_en ? joyana2b : joyana2;
    ana[2] = joyana3;
    ana[3] = joyana4;
    joy[0] = joystick1;
    joy[1] = joystick2;
    joy[2] = joystick3;
    joy[3] = joystick4;
  end

  for (genvar p = 0; p < 4; p++) begin : g_player
    jts16_trackball_axis u_x (
      .clk    (clk),
      .rst    (rst),
      .strobe (strobe),
      .axis   (ana[p][7:0]),
      .plus   (joy[p][0]),
      .minus  (joy[p][1]),
      .count  (cnt[2*p])
    );
    jts16_trackball_axis u_y (
      .clk    (clk),
      .rst    (rst),
      .strobe (strobe),
      .axis   (ana[p][15:8]),
      .plus   (joy[p][2]),
      .minus  (joy[p][3]),
      .count  (cnt[2*p+1])
    );
  end

  assign trackball0 = cnt[0];
  assign trackball1 = cnt[1];
  assign trackball2 = cnt[2];
  assign trackball3 = cnt[3];
  assign trackball4 = cnt[4];
  assign trackball5 = cnt[5];
  assign trackball6 = cnt[6];
  assign trackball7 = cnt[7];

endmodule

// File: tb/tb_jts16_trackball_emu.sv
// Table-driven bench for jts16_trackball_emu plus hand sequences for timing,
// mid-frame input changes and mid-frame reset.
module tb_jts16_trackball_emu;

`ifdef JTS16_TRACKBALL_DIGITAL_EN
  localparam bit DIG = 1'b1;
`else
  localparam bit DIG = 1'b0;
`endif

  typedef struct packed {
    bit               do_reset;
    logic             right_en;
    logic [7:0]       joy1, joy2, joy3, joy4;
    logic [15:0]      ana1, ana2, ana3, ana4, ana1b, ana2b;
    int               edges;
    logic [7:0][11:0] exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        LHBL = 1'b1;
  logic        right_en = 1'b0;
  logic [7:0]  joystick1 = '0, joystick2 = '0, joystick3 = '0, joystick4 = '0;
  logic [15:0] joyana1 = '0, joyana2 = '0, joyana3 = '0, joyana4 = '0;
  logic [15:0] joyana1b = '0, joyana2b = '0;
  logic [11:0] trackball0, trackball1, trackball2, trackball3;
  logic [11:0] trackball4, trackball5, trackball6, trackball7;
  logic [7:0][11:0] tb_out;

  int passed = 0;
  int total  = 0;
  vec_t vecs[$];
  vec_t v;

  assign tb_out = {trackball7, trackball6, trackball5, trackball4,
                   trackball3, trackball2, trackball1, trackball0};

  always #5 clk = ~clk;

  jts16_trackball_emu dut (
    .clk        (clk),
    .rst        (rst),
    .LHBL       (LHBL),
    .right_en   (right_en),
    .joystick1  (joystick1),
    .joystick2  (joystick2),
    .joystick3  (joystick3),
    .joystick4  (joystick4),
    .joyana1    (joyana1),
    .joyana2    (joyana2),
    .joyana3    (joyana3),
    .joyana4    (joyana4),
    .joyana1b   (joyana1b),
    .joyana2b   (joyana2b),
    .trackball0 (trackball0),
    .trackball1 (trackball1),
    .trackball2 (trackball2),
    .trackball3 (trackball3),
    .trackball4 (trackball4),
    .trackball5 (trackball5),
    .trackball6 (trackball6),
    .trackball7 (trackball7)
  );

  task automatic checkOutput(input string name, input logic [11:0] actual, input logic [11:0] expected);
    total++;
    if (actual === expected)
      passed++;
    else
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
  endtask

  task automatic doReset();
    rst  = 1'b1;
    LHBL = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic lineEdges(input int n);
    repeat (n) begin
      LHBL = 1'b0;
      repeat (2) @(posedge clk);
      #1 LHBL = 1'b1;
      repeat (2) @(posedge clk);
      #1;
    end
  endtask

  task automatic clearVec();
    v = '0;
  endtask

  task automatic applyStimulus(input vec_t x, input int idx);
    if (x.do_reset) doReset();
    right_en  = x.right_en;
    joystick1 = x.joy1;
    joystick2 = x.joy2;
    joystick3 = x.joy3;
    joystick4 = x.joy4;
    joyana1   = x.ana1;
    joyana2   = x.ana2;
    joyana3   = x.ana3;
    joyana4   = x.ana4;
    joyana1b  = x.ana1b;
    joyana2b  = x.ana2b;
    lineEdges(x.edges);
    for (int k = 0; k < 8; k++)
      checkOutput($sformatf("vec%0d trackball%0d", idx, k), tb_out[k], x.exp[k]);
  endtask

  initial begin
    // idle frames stay at zero
    clearVec(); v.do_reset = 1; v.edges = 32; vecs.push_back(v);
    // full positive deflection, one strobe then two
    clearVec(); v.do_reset = 1; v.ana1 = 16'h007F; v.edges = 16; v.exp[0] = 12'h00F; vecs.push_back(v);
    clearVec(); v.ana1 = 16'h007F; v.edges = 16; v.exp[0] = 12'h01E; vecs.push_back(v);
    // -128 wraps below zero
    clearVec(); v.do_reset = 1; v.ana2 = 16'h8000; v.edges = 16; v.exp[3] = 12'hFF0; vecs.push_back(v);
    // right stick selected, then deselected with a zero left stick
    clearVec(); v.do_reset = 1; v.right_en = 1; v.ana1b = 16'h0040; v.edges = 16; v.exp[0] = 12'h008; vecs.push_back(v);
    clearVec(); v.right_en = 0; v.ana1b = 16'h0040; v.edges = 16; v.exp[0] = 12'h008; vecs.push_back(v);
    // digital up on player 4, then left+right cancel
    clearVec(); v.do_reset = 1; v.joy4 = 8'h08; v.edges = 16; v.exp[7] = DIG ? 12'hFF8 : 12'h000; vecs.push_back(v);
    clearVec(); v.joy4 = 8'h03; v.edges = 16; v.exp[7] = DIG ? 12'hFF8 : 12'h000; vecs.push_back(v);
    // inside dead zone with right pressed
    clearVec(); v.do_reset = 1; v.ana3 = 16'h0005; v.joy3 = 8'h01; v.edges = 16; v.exp[4] = DIG ? 12'h008 : 12'h000; vecs.push_back(v);
    // dead-zone boundaries: -8 is outside, -7 is inside (down pressed)
    clearVec(); v.do_reset = 1; v.ana4 = 16'hF9F8; v.joy4 = 8'h04; v.edges = 16;
    v.exp[6] = 12'hFFF; v.exp[7] = DIG ? 12'h008 : 12'h000; vecs.push_back(v);
    // +8 is outside, +7 is inside (up pressed)
    clearVec(); v.do_reset = 1; v.ana2 = 16'h0708; v.joy2 = 8'h08; v.edges = 16;
    v.exp[2] = 12'h001; v.exp[3] = DIG ? 12'hFF8 : 12'h000; vecs.push_back(v);
    // right stick for player 2 overrides left; player 3 has no right stick
    clearVec(); v.do_reset = 1; v.right_en = 1; v.ana2b = 16'h0180; v.ana2 = 16'h007F;
    v.ana3 = 16'h0080; v.ana1 = 16'h007F; v.edges = 16;
    v.exp[2] = 12'hFF0; v.exp[4] = 12'hFF0; vecs.push_back(v);

    $display("[TB] starting");
    doReset();
    for (int k = 0; k < 8; k++)
      checkOutput($sformatf("reset trackball%0d", k), tb_out[k], 12'h000);

    for (int i = 0; i < vecs.size(); i++)
      applyStimulus(vecs[i], i);

    // stick moves between strobes are ignored; only the strobe sample counts
    doReset();
    right_en = 1'b0; joystick1 = '0; joystick2 = '0; joystick3 = '0; joystick4 = '0;
    joyana2 = '0; joyana3 = '0; joyana4 = '0; joyana1b = '0; joyana2b = '0;
    joyana1 = 16'h007F;
    lineEdges(15);
    checkOutput("between strobes", trackball0, 12'h000);
    joyana1 = 16'h0000;
    lineEdges(1);
    checkOutput("strobe samples zero", trackball0, 12'h000);
    joyana1 = 16'h007F;
    lineEdges(15);
    checkOutput("before strobe", trackball0, 12'h000);

    // counter changes one clock after the strobe cycle
    LHBL = 1'b0;
    #1;
    checkOutput("strobe cycle", trackball0, 12'h000);
    @(posedge clk);
    #1;
    checkOutput("after strobe edge", trackball0, 12'h00F);
    @(posedge clk);
    #1 LHBL = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("stable after strobe", trackball0, 12'h00F);

    // mid-frame reset clears immediately and restarts the line count
    lineEdges(8);
    rst = 1'b1;
    #1;
    checkOutput("async reset tb0", trackball0, 12'h000);
    @(posedge clk);
    #1 rst = 1'b0;
    lineEdges(15);
    checkOutput("15 ticks after reset", trackball0, 12'h000);
    lineEdges(1);
    checkOutput("16 ticks after reset", trackball0, 12'h00F);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
